// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-source inputs and pipeline-register controls shared between the
// 5-stage pipeline datapath (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        branch_taken;
  logic        md_start;
  logic        md_done;
  logic        imem_ready;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_write;
  logic        if_id_freeze;
  logic        if_id_flush;
  logic        id_ex_freeze;
  logic        id_ex_flush;
  logic        ex_mem_freeze;
  logic        ex_mem_flush;
  logic        mem_wb_flush;
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic        mem_timeout;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rd, branch_taken,
           md_start, md_done, imem_ready, mem_req, mem_ready,
    input  pc_write, if_id_freeze, if_id_flush, id_ex_freeze, id_ex_flush,
           ex_mem_freeze, ex_mem_flush, mem_wb_flush, stall_cnt, flush_cnt,
           mem_timeout
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rd, branch_taken,
           md_start, md_done, imem_ready, mem_req, mem_ready,
    output pc_write, if_id_freeze, if_id_flush, id_ex_freeze, id_ex_flush,
           ex_mem_freeze, ex_mem_flush, mem_wb_flush, stall_cnt, flush_cnt,
           mem_timeout
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: prioritises memory waits,
// multi-cycle mult/div, taken branches, load-use and fetch misses.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_b,
  pipe_hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_BUSY  = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT_LIM = 16'(MEM_TIMEOUT);

  state_t      state_r;
  state_t      eff_state_s;
  logic        md_resume_r;
  logic [15:0] wait_cnt_r;
  logic [15:0] wait_inc_s;
  logic [31:0] stall_cnt_r;
  logic [15:0] flush_cnt_r;
  logic        mem_timeout_r;

  logic mem_stall_s;
  logic load_use_s;
  logic md_busy_s;
  logic branch_s;

  logic pc_write_s;
  logic if_id_freeze_s;
  logic if_id_flush_s;
  logic id_ex_freeze_s;
  logic id_ex_flush_s;
  logic ex_mem_freeze_s;
  logic ex_mem_flush_s;
  logic mem_wb_flush_s;

  assign mem_stall_s = hz.mem_req & ~hz.mem_ready;
  assign load_use_s  = hz.ex_mem_read & (hz.ex_rd != 5'd0) &
                       ((hz.ex_rd == hz.id_rs) | (hz.id_uses_rt & (hz.ex_rd == hz.id_rt)));
  assign wait_inc_s  = (wait_cnt_r == 16'hFFFF) ? wait_cnt_r : (wait_cnt_r + 16'd1);

  // Leaving MEM_WAIT evaluates the resumed state's rules in the same cycle.
  always_comb begin
    eff_state_s = RUN;
    case (state_r)
      RUN:      eff_state_s = RUN;
      MD_BUSY:  eff_state_s = MD_BUSY;
      MEM_WAIT: eff_state_s = md_resume_r ? MD_BUSY : RUN;
      default:  eff_state_s = RUN;
    endcase
  end

  assign md_busy_s = ~mem_stall_s &
                     ((eff_state_s == MD_BUSY) | ((eff_state_s == RUN) & hz.md_start));
  assign branch_s  = ~mem_stall_s & ~md_busy_s & hz.branch_taken;

  // Priority-ordered control decode; never freeze and flush one register together.
  always_comb begin
    pc_write_s      = 1'b1;
    if_id_freeze_s  = 1'b0;
    if_id_flush_s   = 1'b0;
    id_ex_freeze_s  = 1'b0;
    id_ex_flush_s   = 1'b0;
    ex_mem_freeze_s = 1'b0;
    ex_mem_flush_s  = 1'b0;
    mem_wb_flush_s  = 1'b0;
    if (mem_stall_s) begin
      pc_write_s      = 1'b0;
      if_id_freeze_s  = 1'b1;
      id_ex_freeze_s  = 1'b1;
      ex_mem_freeze_s = 1'b1;
      mem_wb_flush_s  = 1'b1;
    end else if (md_busy_s) begin
      pc_write_s     = hz.md_done;
      if_id_freeze_s = 1'b1;
      id_ex_freeze_s = 1'b1;
      ex_mem_flush_s = ~hz.md_done;
    end else if (branch_s) begin
      if_id_flush_s = 1'b1;
      id_ex_flush_s = 1'b1;
    end else if (load_use_s) begin
      pc_write_s     = 1'b0;
      if_id_freeze_s = 1'b1;
      id_ex_flush_s  = 1'b1;
    end else if (~hz.imem_ready) begin
      pc_write_s    = 1'b0;
      if_id_flush_s = 1'b1;
    end else begin
      pc_write_s = 1'b1;
    end
  end

  assign hz.pc_write      = pc_write_s;
  assign hz.if_id_freeze  = if_id_freeze_s;
  assign hz.if_id_flush   = if_id_flush_s;
  assign hz.id_ex_freeze  = id_ex_freeze_s;
  assign hz.id_ex_flush   = id_ex_flush_s;
  assign hz.ex_mem_freeze = ex_mem_freeze_s;
  assign hz.ex_mem_flush  = ex_mem_flush_s;
  assign hz.mem_wb_flush  = mem_wb_flush_s;
  assign hz.stall_cnt     = stall_cnt_r;
  assign hz.flush_cnt     = flush_cnt_r;
  assign hz.mem_timeout   = mem_timeout_r;

  // Hazard FSM with MD resume flag, wait counter and sticky timeout.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r       <= RUN;
      md_resume_r   <= 1'b0;
      wait_cnt_r    <= 16'd0;
      mem_timeout_r <= 1'b0;
    end else if (mem_stall_s) begin
      state_r <= MEM_WAIT;
      case (state_r)
        MD_BUSY:  md_resume_r <= ~hz.md_done;
        MEM_WAIT: md_resume_r <= md_resume_r & ~hz.md_done;
        default:  md_resume_r <= 1'b0;
      endcase
      if (state_r == MEM_WAIT) begin
        wait_cnt_r <= wait_inc_s;
        if (wait_inc_s >= TIMEOUT_LIM) begin
          mem_timeout_r <= 1'b1;
        end else begin
          mem_timeout_r <= mem_timeout_r;
        end
      end else begin
        wait_cnt_r <= 16'd0;
      end
    end else if (md_busy_s) begin
      state_r     <= hz.md_done ? RUN : MD_BUSY;
      md_resume_r <= 1'b0;
    end else begin
      state_r     <= RUN;
      md_resume_r <= 1'b0;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      stall_cnt_r <= 32'd0;
      flush_cnt_r <= 16'd0;
    end else begin
      if (!pc_write_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (branch_s && (flush_cnt_r != 16'hFFFF)) begin
        flush_cnt_r <= flush_cnt_r + 16'd1;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vector table, timeout and
// reset sequences, then random stimulus against a behavioural model.
module tb_pipe_hazard_ctrl;
  localparam int MT = 4;

  logic clk = 1'b0;
  logic rst_b;
  int   n_pass = 0;
  int   n_total = 0;

  pipe_hazard_ctrl_if hz();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(MT)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  // {if_id_freeze, if_id_flush, id_ex_freeze, id_ex_flush, ex_mem_freeze, ex_mem_flush, mem_wb_flush}
  logic [6:0] ctl_act;
  assign ctl_act = {hz.if_id_freeze, hz.if_id_flush, hz.id_ex_freeze, hz.id_ex_flush,
                    hz.ex_mem_freeze, hz.ex_mem_flush, hz.mem_wb_flush};

  localparam logic [6:0] C_IDLE = 7'b0000000;
  localparam logic [6:0] C_LU   = 7'b1001000;
  localparam logic [6:0] C_BR   = 7'b0101000;
  localparam logic [6:0] C_IMIS = 7'b0100000;
  localparam logic [6:0] C_MD   = 7'b1010010;
  localparam logic [6:0] C_MDD  = 7'b1010000;
  localparam logic [6:0] C_MEM  = 7'b1010101;

  typedef struct {
    logic [4:0] rs, rt;
    logic       ut, mr;
    logic [4:0] rd;
    logic       br, mds, mdd, imr, mreq, mrdy;
    logic       pc;
    logic [6:0] ctl;
    int         sc, fc;
  } vec_t;

  vec_t tbl[27];

  function automatic vec_t mkv(input logic [4:0] rs, input logic [4:0] rt, input logic ut,
                               input logic mr, input logic [4:0] rd, input logic br,
                               input logic mds, input logic mdd, input logic imr,
                               input logic mreq, input logic mrdy, input logic pc,
                               input logic [6:0] ctl, input int sc, input int fc);
    vec_t v;
    v.rs = rs; v.rt = rt; v.ut = ut; v.mr = mr; v.rd = rd; v.br = br;
    v.mds = mds; v.mdd = mdd; v.imr = imr; v.mreq = mreq; v.mrdy = mrdy;
    v.pc = pc; v.ctl = ctl; v.sc = sc; v.fc = fc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic ut,
                       input logic mr, input logic [4:0] rd, input logic br,
                       input logic mds, input logic mdd, input logic imr,
                       input logic mreq, input logic mrdy);
    hz.id_rs = rs; hz.id_rt = rt; hz.id_uses_rt = ut; hz.ex_mem_read = mr;
    hz.ex_rd = rd; hz.branch_taken = br; hz.md_start = mds; hz.md_done = mdd;
    hz.imem_ready = imr; hz.mem_req = mreq; hz.mem_ready = mrdy;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // Behavioural model state: outstanding mult/div, consecutive stall run, statistics.
  bit     m_pending;
  int     m_run;
  longint m_stall, m_flush;
  bit     m_to;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_b = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b1;
    @(negedge clk);
    chk("rst_pc", 32'(hz.pc_write), 32'd1);
    chk("rst_ctl", 32'(ctl_act), 32'(C_IDLE));
    chk("rst_stall", hz.stall_cnt, 32'd0);
    chk("rst_flush", 32'(hz.flush_cnt), 32'd0);
    chk("rst_to", 32'(hz.mem_timeout), 32'd0);

    //               rs    rt    ut mr rd    br md mdd imr mrq mrdy pc ctl   sc  fc
    tbl[0]  = mkv(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, 0, 1, C_IDLE, 0, 0);
    tbl[1]  = mkv(5'd5, 5'd0, 0, 1, 5'd5, 0, 0, 0, 1, 0, 0, 0, C_LU,   0, 0);
    tbl[2]  = mkv(5'd5, 5'd0, 0, 0, 5'd5, 0, 0, 0, 1, 0, 0, 1, C_IDLE, 1, 0);
    tbl[3]  = mkv(5'd0, 5'd0, 0, 1, 5'd0, 0, 0, 0, 1, 0, 0, 1, C_IDLE, 1, 0);
    tbl[4]  = mkv(5'd3, 5'd7, 1, 1, 5'd7, 0, 0, 0, 1, 0, 0, 0, C_LU,   1, 0);
    tbl[5]  = mkv(5'd3, 5'd7, 0, 1, 5'd7, 0, 0, 0, 1, 0, 0, 1, C_IDLE, 2, 0);
    tbl[6]  = mkv(5'd5, 5'd0, 0, 1, 5'd5, 1, 0, 0, 1, 0, 0, 1, C_BR,   2, 0);
    tbl[7]  = mkv(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, 0, 1, C_IDLE, 2, 1);
    tbl[8]  = mkv(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 0, C_IMIS, 2, 1);
    tbl[9]  = mkv(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 0, C_IMIS, 3, 1);
    tbl[10] = mkv(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, 0, 1, C_IDLE, 4, 1);
    tbl[11] = mkv(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 1, 0, 0, 0, C_MD,   4, 1);
    for (int i = 12; i <= 16; i++)
      tbl[i] = mkv(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, 0, 0, C_MD, i - 7, 1);
    tbl[17] = mkv(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, 0, 0, 1, C_MDD, 10, 1);
    tbl[18] = mkv(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, 0, 1, C_IDLE, 10, 1);
    tbl[19] = mkv(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 1, 0, 0, 0, C_MD,  10, 1);
    tbl[20] = mkv(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 1, 0, 0, C_MEM, 11, 1);
    tbl[21] = mkv(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 1, 0, 0, C_MEM, 12, 1);
    tbl[22] = mkv(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 1, 0, 0, C_MEM, 13, 1);
    tbl[23] = mkv(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 1, 1, 0, C_MD,  14, 1);
    tbl[24] = mkv(5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 0, 1, 0, 0, 0, C_MD,  15, 1);
    tbl[25] = mkv(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, 0, 0, 1, C_MDD, 16, 1);
    tbl[26] = mkv(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, 0, 1, C_IDLE, 16, 1);

    for (int i = 0; i < 27; i++) begin
      @(posedge clk);
      #1 drive(tbl[i].rs, tbl[i].rt, tbl[i].ut, tbl[i].mr, tbl[i].rd, tbl[i].br,
               tbl[i].mds, tbl[i].mdd, tbl[i].imr, tbl[i].mreq, tbl[i].mrdy);
      @(negedge clk);
      chk($sformatf("v%0d_pc", i), 32'(hz.pc_write), 32'(tbl[i].pc));
      chk($sformatf("v%0d_ctl", i), 32'(ctl_act), 32'(tbl[i].ctl));
      chk($sformatf("v%0d_stall", i), hz.stall_cnt, 32'(tbl[i].sc));
      chk($sformatf("v%0d_flush", i), 32'(hz.flush_cnt), 32'(tbl[i].fc));
    end

    // Data-memory timeout: six stall cycles, flag seen once four MEM_WAIT cycles elapsed.
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1 begin idle(); hz.mem_req = 1'b1; hz.mem_ready = 1'b0; end
      @(negedge clk);
      chk($sformatf("to_ctl%0d", k), 32'(ctl_act), 32'(C_MEM));
      chk($sformatf("to_flag%0d", k), 32'(hz.mem_timeout), (k >= 5) ? 32'd1 : 32'd0);
    end
    @(posedge clk);
    #1 begin idle(); hz.mem_req = 1'b1; hz.mem_ready = 1'b1; end
    @(negedge clk);
    chk("to_exit_pc", 32'(hz.pc_write), 32'd1);
    chk("to_exit_flag", 32'(hz.mem_timeout), 32'd1);
    @(posedge clk);
    #1 idle();
    @(negedge clk);
    chk("to_sticky", 32'(hz.mem_timeout), 32'd1);

    // Reset pulsed mid-wait while an MD op is remembered.
    @(posedge clk);
    #1 begin idle(); hz.md_start = 1'b1; end
    @(negedge clk);
    chk("rw_md", 32'(ctl_act), 32'(C_MD));
    @(posedge clk);
    #1 begin idle(); hz.mem_req = 1'b1; end
    @(negedge clk);
    chk("rw_mem", 32'(ctl_act), 32'(C_MEM));
    @(posedge clk);
    #2 rst_b = 1'b0;
    #1;
    chk("rw_stall", hz.stall_cnt, 32'd0);
    chk("rw_flush", 32'(hz.flush_cnt), 32'd0);
    chk("rw_to", 32'(hz.mem_timeout), 32'd0);
    idle();
    @(posedge clk);
    #1 rst_b = 1'b1;
    @(negedge clk);
    chk("rw_run_pc", 32'(hz.pc_write), 32'd1);
    chk("rw_run_ctl", 32'(ctl_act), 32'(C_IDLE));

    // Random stimulus against the behavioural model.
    m_pending = 0; m_run = 0; m_stall = 0; m_flush = 0; m_to = 0;
    for (int n = 0; n < 600; n++) begin
      logic [4:0] rs, rt, rd;
      logic ut, mr, br, mds, mdd, imr, mreq, mrdy;
      logic e_pc, stall, busy, lu, brf;
      logic [6:0] e_ctl;
      rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
      ut = 1'($urandom_range(0, 1)); mr = 1'($urandom_range(0, 1));
      br = ($urandom_range(0, 4) == 0); mds = ($urandom_range(0, 9) == 0);
      mdd = ($urandom_range(0, 6) == 0); imr = ($urandom_range(0, 6) != 0);
      mreq = ($urandom_range(0, 2) == 0); mrdy = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1 drive(rs, rt, ut, mr, rd, br, mds, mdd, imr, mreq, mrdy);

      stall = mreq && !mrdy;
      busy  = !stall && (m_pending || mds);
      lu    = mr && (rd != 0) && ((rd == rs) || (ut && rd == rt));
      brf   = 1'b0;
      if (stall) begin e_pc = 0; e_ctl = C_MEM; end
      else if (busy) begin e_pc = mdd; e_ctl = mdd ? C_MDD : C_MD; end
      else if (br) begin e_pc = 1; e_ctl = C_BR; brf = 1'b1; end
      else if (lu) begin e_pc = 0; e_ctl = C_LU; end
      else if (!imr) begin e_pc = 0; e_ctl = C_IMIS; end
      else begin e_pc = 1; e_ctl = C_IDLE; end

      @(negedge clk);
      chk("rnd_pc", 32'(hz.pc_write), 32'(e_pc));
      chk("rnd_ctl", 32'(ctl_act), 32'(e_ctl));
      chk("rnd_stall", hz.stall_cnt, 32'(m_stall));
      chk("rnd_flush", 32'(hz.flush_cnt), 32'(m_flush));
      chk("rnd_to", 32'(hz.mem_timeout), 32'(m_to));

      if (!e_pc && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (brf && m_flush < 65535) m_flush++;
      if (stall) begin
        if (mdd) m_pending = 0;
        m_run++;
        if (m_run - 1 >= MT) m_to = 1;
      end else begin
        m_run = 0;
        if (busy) m_pending = !mdd;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage MIPS pipeline. It drives `freeze`/`flush` on the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and `pc_write` on the PC. It sequences four hazard sources:
- load-use hazards
- taken branches
- multi-cycle multiply/divide in EX
- variable-latency instruction and data memory

It also keeps stall/flush statistics and a data-memory timeout flag.

## Interface
Parameters:
- MEM_TIMEOUT, 255: number of consecutive MEM_WAIT cycles after which `mem_timeout` sets (1..65535).

Ports:
- clk  in  1  clock, rising edge
- rst_b  in  1  reset, asynchronous, active-low
- id_rs, id_rt  in  5 each  source register numbers of the instruction in ID
- id_uses_rt  in  1  instruction in ID reads rt
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  5  destination register of the instruction in EX
- branch_taken  in  1  branch in EX resolved taken (valid only when not stalled)
- md_start  in  1  single-cycle pulse: mult/div issued in EX
- md_done  in  1  single-cycle pulse: mult/div result valid this cycle
- imem_ready  in  1  instruction fetch completes this cycle
- mem_req  in  1  MEM stage issues a load/store
- mem_ready  in  1  data memory completes this cycle
- pc_write  out  1  PC loads its next value
- if_id_freeze, if_id_flush  out  1 each  IF/ID controls
- id_ex_freeze, id_ex_flush  out  1 each  ID/EX controls
- ex_mem_freeze, ex_mem_flush  out  1 each  EX/MEM controls
- mem_wb_flush  out  1  insert bubble into MEM/WB
- stall_cnt  out  32  cycles with pc_write=0, saturating
- flush_cnt  out  16  branch flushes, saturating
- mem_timeout  out  1  sticky; cleared only by reset

## Operation
- States: RUN, MD_BUSY, MEM_WAIT. Reset state is RUN.
- Control outputs are combinational from the state and inputs. Registers honour freeze over flush; this block never asserts both on one register.
- Condition terms:
  - mem_stall = mem_req & ~mem_ready
  - load_use = ex_mem_read & (ex_rd≠0) & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt))
- Priority: mem_stall > MD busy > branch_taken > load_use > ~imem_ready. The lower rows apply only when no higher row is active.
  1. mem_stall, any state: pc_write=0; if_id/id_ex/ex_mem freeze=1; mem_wb_flush=1; next state MEM_WAIT. If the current state is MD_BUSY, MD_BUSY is remembered and resumed on exit unless md_done was seen meanwhile.
  2. MD busy (state MD_BUSY, or RUN with md_start): pc_write=0; if_id/id_ex freeze=1; ex_mem_flush=1.
     - md_done: the EX/MEM bubble is removed that cycle; pc_write=1; next state RUN.
     - md_start in RUN without same-cycle md_done: next state MD_BUSY.
  3. branch_taken: pc_write=1; if_id_flush=1; id_ex_flush=1; flush_cnt+1.
  4. load_use: pc_write=0; if_id_freeze=1; id_ex_flush=1. This is a one-cycle stall with no state change.
  5. ~imem_ready: pc_write=0; if_id_flush=1.
  - No hazard: pc_write=1; all other control outputs 0.
- MEM_WAIT behaviour:
  - Applies row 1 while mem_stall holds.
  - On mem_ready: returns to RUN (or MD_BUSY), and evaluates that state's rules in the same cycle.
  - wait_cnt (16-bit) clears on entry and increments each MEM_WAIT cycle. When wait_cnt reaches MEM_TIMEOUT, mem_timeout sets. The pipeline keeps waiting.
- Counters:
  - stall_cnt increments each cycle pc_write=0 and saturates at 2^32-1.
  - flush_cnt saturates at 65535.
- Reset mid-operation: state returns to RUN immediately. Counters, wait_cnt and mem_timeout clear to 0.

## Timing
- Reset values:
  - state RUN; stall_cnt=0, flush_cnt=0, mem_timeout=0.
  - With idle inputs (imem_ready=1, all others 0): pc_write=1, all freeze/flush outputs 0.
- Control latency is zero cycles: outputs respond in the same cycle as the inputs and take effect at the next clk edge in the pipeline registers.
- State, counters and mem_timeout update on clk rising edge.
- Load-use stall: exactly 1 cycle.
- MD stall length: from md_start through the cycle before md_done, plus any mem stall cycles.
- mem_timeout rises at the edge ending the MEM_TIMEOUT-th consecutive wait cycle.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5, id_rs=5 → one cycle with pc_write=0, if_id_freeze=1, id_ex_flush=1, stall_cnt=1. Repeat with ex_rd=0 → no stall.
- Branch plus load-use in the same cycle: branch_taken=1 → pc_write=1, if_id_flush=id_ex_flush=1, no freeze, flush_cnt=1.
- Mult/div: md_start at cycle 0, md_done at cycle 6 → pc_write=0 and ex_mem_flush=1 for cycles 0-5. Cycle 6: pc_write=1 and state RUN.
- Data-memory wait during MD_BUSY: mem_req=1, mem_ready=0 for 3 cycles → all freezes=1 and mem_wb_flush=1 for those cycles; then MD_BUSY resumes.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 for 6 cycles → mem_timeout=1 after the 4th wait cycle. It stays 1 after mem_ready, and clears only when rst_b is pulsed low mid-wait (state RUN, counters 0).
- Fetch miss: imem_ready=0 for 2 cycles → pc_write=0 and if_id_flush=1 for both cycles; stall_cnt=2.
